// File: rtl/drac_pkg.sv
// Shared types and default sizing for the register file slice.
package drac_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } rf_state_t;

   localparam int REGFILE_DATA_W   = 64;
   localparam int REGFILE_NUM_REGS = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by alloc, cleared by any write, looked up per read port.
module regfile_scoreboard #(
   parameter  int NUM_REGS = 32,
   parameter  int NUM_RD   = 2,
   parameter  int NUM_WR   = 2,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 en_i,
   input  logic [NUM_WR-1:0]    we_i,
   input  logic [NUM_WR*AW-1:0] waddr_i,
   input  logic                 alloc_i,
   input  logic [AW-1:0]        alloc_addr_i,
   input  logic [NUM_RD*AW-1:0] raddr_i,
   output logic [NUM_RD-1:0]    rbusy_o
);

   logic [NUM_REGS-1:0] busy_q, busy_d;

   // Alloc is applied after the write clears so a new producer wins a same-edge collision.
   always_comb begin
      busy_d = busy_q;
      if (en_i) begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (we_i[k]) busy_d[waddr_i[k*AW +: AW]] = 1'b0;
         end
         if (alloc_i) busy_d[alloc_addr_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) busy_q <= '0;
      else         busy_q <= busy_d;
   end

   always_comb begin
      rbusy_o = '0;
      for (int l = 0; l < NUM_RD; l++) begin
         rbusy_o[l] = busy_q[raddr_i[l*AW +: AW]];
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with hardware zero-initialisation and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
   import drac_pkg::*;
#(
   parameter  int DATA_W   = REGFILE_DATA_W,
   parameter  int NUM_REGS = REGFILE_NUM_REGS,
   parameter  int NUM_RD   = 2,
   parameter  int NUM_WR   = 2,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic [NUM_WR-1:0]        we_i,
   input  logic [NUM_WR*AW-1:0]     waddr_i,
   input  logic [NUM_WR*DATA_W-1:0] wdata_i,
   input  logic [NUM_RD*AW-1:0]     raddr_i,
   output logic [NUM_RD*DATA_W-1:0] rdata_o,
   output logic [NUM_RD-1:0]        rbusy_o,
   input  logic                     alloc_i,
   input  logic [AW-1:0]            alloc_addr_i,
   output logic                     ready_o
);

   rf_state_t         state_q, state_d;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] mem_q [NUM_REGS];
   logic [NUM_RD-1:0] sb_rbusy;
   logic              rdy;

   assign rdy     = (state_q == READY);
   assign ready_o = rdy;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == INIT) begin
         cnt_d = cnt_q + AW'(1);
         if (cnt_q == AW'(NUM_REGS - 1)) state_d = READY;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= INIT;
         cnt_q   <= AW'(1);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Storage has no reset; INIT sweeps zeros through it. Later ports overwrite earlier ones.
   always_ff @(posedge clk_i) begin
      if (!rdy) begin
         mem_q[cnt_q] <= '0;
      end else begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (we_i[k] && (waddr_i[k*AW +: AW] != '0))
               mem_q[waddr_i[k*AW +: AW]] <= wdata_i[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      logic [AW-1:0] ra;
      ra      = '0;
      rdata_o = '0;
      for (int l = 0; l < NUM_RD; l++) begin
         ra = raddr_i[l*AW +: AW];
         if (rdy && (ra != '0)) begin
            rdata_o[l*DATA_W +: DATA_W] = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NUM_WR; k++) begin
               if (we_i[k] && (waddr_i[k*AW +: AW] == ra))
                  rdata_o[l*DATA_W +: DATA_W] = wdata_i[k*DATA_W +: DATA_W];
            end
`endif
         end
      end
   end

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR)
   ) u_scoreboard (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .en_i         (rdy),
      .we_i         (we_i),
      .waddr_i      (waddr_i),
      .alloc_i      (alloc_i),
      .alloc_addr_i (alloc_addr_i),
      .raddr_i      (raddr_i),
      .rbusy_o      (sb_rbusy)
   );

   assign rbusy_o = sb_rbusy & {NUM_RD{rdy}};

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

   localparam int DATA_W   = 64;
   localparam int NUM_REGS = 32;
   localparam int NUM_RD   = 2;
   localparam int NUM_WR   = 2;
   localparam int AW       = 5;

   logic                     clk;
   logic                     rstn;
   logic [NUM_WR-1:0]        we;
   logic [NUM_WR*AW-1:0]     waddr;
   logic [NUM_WR*DATA_W-1:0] wdata;
   logic [NUM_RD*AW-1:0]     raddr;
   logic [NUM_RD*DATA_W-1:0] rdata;
   logic [NUM_RD-1:0]        rbusy;
   logic                     alloc;
   logic [AW-1:0]            alloc_addr;
   logic                     ready;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] m_mem  [NUM_REGS];
   bit                m_busy [NUM_REGS];
   int                m_edges;

   regfile_mp #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR)
   ) dut (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .we_i         (we),
      .waddr_i      (waddr),
      .wdata_i      (wdata),
      .raddr_i      (raddr),
      .rdata_o      (rdata),
      .rbusy_o      (rbusy),
      .alloc_i      (alloc),
      .alloc_addr_i (alloc_addr),
      .ready_o      (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit m_ready();
      return m_edges >= NUM_REGS - 1;
   endfunction

   function automatic logic [DATA_W-1:0] exp_rd(input logic [AW-1:0] a);
      logic [DATA_W-1:0] v;
      if (!m_ready() || a == 0) return '0;
      v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NUM_WR; k++)
         if (we[k] && waddr[k*AW +: AW] == a) v = wdata[k*DATA_W +: DATA_W];
`endif
      return v;
   endfunction

   function automatic bit exp_busy(input logic [AW-1:0] a);
      if (!m_ready() || a == 0) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic idle();
      we = '0; waddr = '0; wdata = '0; raddr = '0; alloc = 1'b0; alloc_addr = '0;
   endtask

   task automatic rand_inputs(input bit narrow);
      int hi;
      hi = narrow ? 7 : NUM_REGS - 1;
      we = NUM_WR'($urandom());
      for (int k = 0; k < NUM_WR; k++) begin
         waddr[k*AW +: AW]      = AW'($urandom_range(0, hi));
         wdata[k*DATA_W +: DATA_W] = {$urandom(), $urandom()};
      end
      for (int l = 0; l < NUM_RD; l++) raddr[l*AW +: AW] = AW'($urandom_range(0, hi));
      alloc      = ($urandom_range(0, 2) == 0);
      alloc_addr = AW'($urandom_range(0, hi));
   endtask

   // Compare combinational outputs, advance one clock, then apply the spec's update rules.
   task automatic cycle(input string tag);
      logic [AW-1:0] a;
      #1;
      check({tag, "/ready"}, 64'(ready), 64'(m_ready()));
      for (int l = 0; l < NUM_RD; l++) begin
         a = raddr[l*AW +: AW];
         check({tag, "/rdata"}, rdata[l*DATA_W +: DATA_W], exp_rd(a));
         check({tag, "/rbusy"}, 64'(rbusy[l]), 64'(exp_busy(a)));
      end
      @(posedge clk);
      if (m_ready()) begin
         for (int k = 0; k < NUM_WR; k++) begin
            a = waddr[k*AW +: AW];
            if (we[k] && a != 0) begin
               m_mem[a]  = wdata[k*DATA_W +: DATA_W];
               m_busy[a] = 1'b0;
            end
         end
         if (alloc && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
      end else begin
         m_edges++;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      rstn = 1'b0;
      #1;
      check("rst/ready", 64'(ready), 64'd0);
      check("rst/rbusy", 64'(rbusy), 64'd0);
      for (int i = 0; i < NUM_REGS; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 1'b0;
      end
      m_edges = 0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic run_init(input int n);
      for (int i = 0; i < n; i++) begin
         rand_inputs(1'b0);
         cycle("init");
      end
      idle();
   endtask

   task automatic sweep_clean(input string tag);
      for (int a = 1; a < NUM_REGS; a += 2) begin
         raddr = {AW'(a + 1), AW'(a)};
         #1;
         check({tag, "/zero0"}, rdata[DATA_W-1:0], 64'd0);
         check({tag, "/busy0"}, 64'(rbusy[0]), 64'd0);
         cycle(tag);
      end
   endtask

   initial begin
      idle();
      rstn = 1'b0;
      @(negedge clk);
      do_reset();

      run_init(NUM_REGS - 1);
      #1;
      check("ready_at_31", 64'(ready), 64'd1);
      sweep_clean("post_init");

      // Both ports hit r5; port 1 must win.
      we = 2'b11; waddr = {AW'(5), AW'(5)};
      wdata = {64'h5555, 64'hAAAA};
      raddr = {AW'(0), AW'(5)};
      cycle("dual_wr");
      we = '0;
      #1;
      check("port_win", rdata[DATA_W-1:0], 64'h5555);
      cycle("dual_wr_rd");

      // r0 is hardwired: writes and allocs are dropped.
      we = 2'b01; waddr = '0; wdata = {64'h0, 64'hFFFF};
      alloc = 1'b1; alloc_addr = '0; raddr = '0;
      cycle("r0_wr");
      idle();
      #1;
      check("r0_data", rdata[DATA_W-1:0], 64'd0);
      check("r0_busy", 64'(rbusy[0]), 64'd0);
      cycle("r0_rd");

      // Busy set by alloc, survives a colliding write, cleared by a plain write.
      alloc = 1'b1; alloc_addr = AW'(7); raddr = {AW'(0), AW'(7)};
      cycle("alloc7");
      alloc = 1'b0;
      #1;
      check("r7_busy_set", 64'(rbusy[0]), 64'd1);
      we = 2'b01; waddr = {AW'(0), AW'(7)}; wdata = {64'h0, 64'h12};
      alloc = 1'b1; alloc_addr = AW'(7);
      cycle("wr_alloc7");
      we = '0; alloc = 1'b0;
      #1;
      check("r7_busy_kept", 64'(rbusy[0]), 64'd1);
      check("r7_data", rdata[DATA_W-1:0], 64'h12);
      we = 2'b01; wdata = {64'h0, 64'h34};
      cycle("wr7");
      we = '0;
      #1;
      check("r7_busy_clr", 64'(rbusy[0]), 64'd0);
      cycle("rd7");

      // Same-cycle read of a register being written.
      we = 2'b01; waddr = {AW'(0), AW'(3)}; wdata = {64'h0, 64'h1111};
      cycle("wr3_old");
      wdata = {64'h0, 64'hBEEF}; raddr = {AW'(0), AW'(3)};
      #1;
`ifdef REGFILE_BYPASS_EN
      check("bypass_r3", rdata[DATA_W-1:0], 64'hBEEF);
`else
      check("no_bypass_r3", rdata[DATA_W-1:0], 64'h1111);
`endif
      cycle("wr3_new");
      idle();

      for (int i = 0; i < 400; i++) begin
         rand_inputs(i[0]);
         cycle("rand");
      end

      // Reset from READY, then again partway through INIT.
      do_reset();
      run_init(10);
      do_reset();
      run_init(NUM_REGS - 1);
      #1;
      check("ready_after_restart", 64'(ready), 64'd1);
      sweep_clean("restart");

      for (int i = 0; i < 100; i++) begin
         rand_inputs(1'b1);
         cycle("rand2");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning architectural register count (power of two, >=4); AW=$clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of read ports.
REQ-004 SHALL have parameter NUM_WR, default 2, meaning number of write ports.
REQ-005 SHALL have ports: clk_i  in  1  sole clock, rising edge; rstn_i  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: we_i  in  NUM_WR  per-port write enable; waddr_i  in  NUM_WR*AW  write addresses; wdata_i  in  NUM_WR*DATA_W  write data.
REQ-007 SHALL have ports: raddr_i  in  NUM_RD*AW  read addresses; rdata_o  out  NUM_RD*DATA_W  read data; rbusy_o  out  NUM_RD  pending-producer flag per read port.
REQ-008 SHALL have ports: alloc_i  in  1  mark register busy; alloc_addr_i  in  AW  register to mark; ready_o  out  1  block initialised.

Function
REQ-009 SHALL implement FSM states INIT and READY; reset enters INIT.
REQ-010 In INIT, SHALL zero one register per cycle, addresses 1..NUM_REGS-1 ascending, via an internal counter.
REQ-011 SHALL transition INIT->READY on the edge that writes register NUM_REGS-1; ready_o rises exactly NUM_REGS-1 cycles after rstn_i deasserts and stays high until next reset.
REQ-012 In INIT, SHALL ignore we_i and alloc_i, drive rdata_o all-zero and rbusy_o all-zero.
REQ-013 In READY, SHALL write wdata_i lane k to waddr_i lane k on the rising edge when we_i[k]=1 and address !=0.
REQ-014 Writes to address 0 SHALL be discarded; reads of address 0 SHALL return 0 and rbusy 0.
REQ-015 Two write ports to the same address in one cycle: highest-numbered port SHALL win.
REQ-016 Read ports SHALL be combinational (zero latency) from stored contents, subject to REQ-023.
REQ-017 Per-register busy bit SHALL be set on the edge where alloc_i=1 (address !=0), and cleared on the edge where any we_i write targets it.
REQ-018 Simultaneous alloc and write to the same register: busy SHALL end set (new producer wins); data still written.
REQ-019 rbusy_o lane SHALL reflect the registered busy bit of raddr_i lane (no same-cycle bypass of busy state).

Reset
REQ-020 rstn_i low SHALL asynchronously: force INIT, counter to 1, all busy bits to 0, ready_o to 0.
REQ-021 Storage array SHALL NOT be reset directly; contents are undefined until INIT completes.
REQ-022 Reset asserted mid-INIT or in READY SHALL restart the full INIT sequence.

Configuration
REQ-023 Macro REGFILE_BYPASS_EN defined: read lane whose address matches an enabled same-cycle write (READY, addr !=0) SHALL return that write data (highest port on multi-match); undefined: reads SHALL return pre-edge stored value only.

Structure
REQ-024 Shared package drac_pkg SHALL hold: rf_state_t enum (INIT, READY) and default constants REGFILE_DATA_W=64, REGFILE_NUM_REGS=32.
REQ-025 SHALL instantiate one sub-module, regfile_scoreboard, owning busy bits, alloc/clear logic and rbusy lookup.

Verification
REQ-026 Release reset, NUM_REGS=32 -> ready_o=0 for cycles 0..30, =1 at cycle 31; all reads of r1..r31 return 0.
REQ-027 READY; we_i=2'b11, waddr both 5, wdata0=0xAAAA, wdata1=0x5555 -> next cycle read r5 = 0x5555.
REQ-028 Write r0=0xFFFF, alloc r0 -> read r0 = 0, rbusy 0.
REQ-029 alloc r7, next cycle rbusy(r7)=1; write r7=0x12 with alloc r7 same cycle -> rbusy stays 1, data 0x12; write again -> rbusy 0.
REQ-030 With REGFILE_BYPASS_EN, write r3=0xBEEF and read r3 same cycle -> rdata=0xBEEF; without macro -> old value.
REQ-031 Assert rstn_i at INIT cycle 10 -> ready_o low, full 31-cycle sequence restarts, busy bits all cleared.
